spi_burst_arb: RTL
==================

SPI_BURST_ARB -- requirements
Module: spi_burst_arb

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of the burst-length fields; a burst is 1 to 2^LEN_W bytes.
REQ-002 SHALL have parameter TO_CYC, default 512, the watchdog limit in clk cycles per byte (used only under REQ-030).
REQ-003 SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 SHALL have ports, in order:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester burst request; bit i is requester i.
- len0, len1  in  LEN_W  burst byte count minus 1 for requester 0 and requester 1.
- wbyte0, wbyte1  in  8  next transmit byte from requester 0 and requester 1.
- gnt  out  2  one-hot owner of the SPI master; all zero when idle.
- wb_pop  out  2  one-cycle pulse: the owner's wbyte was consumed.
- rb_vld  out  2  one-cycle pulse: rb_data holds a received byte for that requester.
- rb_data  out  8  received byte.
- done  out  2  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse on watchdog abort.
- spi_start  out  1  drives the master's apb_ready.
- spi_wdata  out  8  drives the master's WDATA.
- spi_rdy  in  1  the master's SPI_status_RDY_BSYbar; 1 means ready.
- spi_rx_valid  in  1  the master's rx_data_valid.
- spi_rdata  in  8  the master's RDATA.

Function
REQ-005 SHALL implement an FSM with the states IDLE, ISSUE, WAIT and DONE.
REQ-006 IDLE: when req is non-zero, SHALL select an owner, set gnt, latch that requester's len into a length register and clear the byte counter, then go to ISSUE on the next cycle.
REQ-007 Arbitration SHALL be round-robin.
- If both req bits are set, the requester not granted last wins.
- After reset, requester 0 wins.
REQ-008 ISSUE: while spi_rdy=0, SHALL hold in ISSUE with spi_start=0.
REQ-009 ISSUE: when spi_rdy=1, SHALL do all of the following in the same cycle, then go to WAIT.
- Assert spi_start for exactly one cycle.
- Drive spi_wdata with the owner's wbyte.
- Pulse wb_pop for the owner.
REQ-010 spi_wdata SHALL hold its value until the next spi_start; outside spi_start it is don't-care for the master.
REQ-011 WAIT: on spi_rx_valid=1, SHALL register spi_rdata onto rb_data and pulse rb_vld for the owner in the following cycle.
REQ-012 WAIT: on spi_rx_valid=1, SHALL go to DONE when the counter equals the latched length; otherwise it increments the counter and goes to ISSUE.
REQ-013 DONE: SHALL pulse done for the owner for one cycle, clear gnt, record the owner as last-granted, and return to IDLE.
REQ-014 DONE lasts one cycle, so a pending request is re-arbitrated in IDLE on the cycle after DONE.
REQ-015 The latched length SHALL be used for the whole burst; changes to len0 or len1 mid-burst are ignored.
REQ-016 Deasserting req mid-burst SHALL NOT abort the burst.
- The burst completes and done still pulses.
- The requester discards the unwanted bytes.
REQ-017 spi_rx_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-018 gnt, wb_pop, rb_vld and done SHALL never have more than one bit set.
REQ-019 Minimum byte spacing SHALL be: spi_start, then the master latency to spi_rx_valid, then one cycle for rb_vld, with the next ISSUE able to fire in that same cycle.
REQ-020 The counter SHALL be LEN_W bits wide; len=2^LEN_W-1 yields exactly 2^LEN_W bytes with no wrap before DONE.

Reset
REQ-021 When rst_n=0, the block SHALL asynchronously take the following values:
- FSM state = IDLE.
- gnt, wb_pop, rb_vld, done = 0.
- err = 0.
- spi_start = 0.
- spi_wdata = 0.
- rb_data = 0.
- Counter = 0.
- Last-granted = requester 1, so that requester 0 wins first.
REQ-022 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after release, the block re-arbitrates from IDLE.

Configuration
REQ-030 When SPI_BURST_TIMEOUT_EN is defined, a watchdog SHALL count cycles spent in WAIT; at TO_CYC cycles without spi_rx_valid, the block SHALL do all of the following:
- Pulse err.
- Pulse done for the owner.
- Clear gnt.
- Return to IDLE through DONE.
REQ-031 The watchdog counter SHALL reset on every spi_start.
REQ-032 When SPI_BURST_TIMEOUT_EN is not defined, there SHALL be no watchdog logic, err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-040 Single byte: req=01, len0=0, wbyte0=0xA5, spi_rdy=1, and spi_rx_valid with spi_rdata=0x3C N cycles after start -> one spi_start with spi_wdata=0xA5, one wb_pop[0], rb_vld[0] with rb_data=0x3C, then one done[0].
REQ-041 Contention: req=11 after reset with len0=len1=1 -> gnt=01 with 2 bytes and done[0], then gnt=10 with 2 bytes and done[1].
REQ-042 Fairness: both requesters held with len=0 for 6 bursts -> grants alternate 0,1,0,1,0,1.
REQ-043 Back-pressure: spi_rdy=0 for 20 cycles in ISSUE -> spi_start stays 0 throughout and fires on the first cycle with spi_rdy=1.
REQ-044 Max length and reset: len1=15 -> exactly 16 spi_start pulses and one done[1]; a repeat run with rst_n pulsed low after byte 5 -> all outputs return to 0 immediately and there is no done pulse.
REQ-045 With SPI_BURST_TIMEOUT_EN and TO_CYC=16, spi_rx_valid never returned -> err and done for the owner pulse 16 cycles after spi_start, then the block returns to IDLE.

Source files
------------

// File: rtl/spi_burst_arb.sv
// Round-robin arbiter that lets two requesters run byte-by-byte bursts on one shared SPI master.
// Define SPI_BURST_TIMEOUT_EN to add a watchdog that aborts a burst stuck in WAIT.

module spi_burst_arb #(
   parameter int LEN_W  = 4,
   parameter int TO_CYC = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic [7:0]       wbyte0,
   input  logic [7:0]       wbyte1,
   output logic [1:0]       gnt,
   output logic [1:0]       wb_pop,
   output logic [1:0]       rb_vld,
   output logic [7:0]       rb_data,
   output logic [1:0]       done,
   output logic             err,
   output logic             spi_start,
   output logic [7:0]       spi_wdata,
   input  logic             spi_rdy,
   input  logic             spi_rx_valid,
   input  logic [7:0]       spi_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state, state_nx;
   logic [LEN_W-1:0] len_q, cnt;
   logic             last, pick, timeout;
   logic [7:0]       wdata_q, wbyte_sel;

   // Index of the winner: the one not granted last when both ask.
   assign pick      = (req == 2'b11) ? ~last : req[1];
   assign wbyte_sel = gnt[1] ? wbyte1 : wbyte0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      spi_start = 1'b0;
      wb_pop    = 2'b00;
      done      = 2'b00;
      spi_wdata = wdata_q;
      case (state)
         IDLE: begin
            if (req != 2'b00) state_nx = ISSUE;
         end
         ISSUE: begin
            if (spi_rdy) begin
               spi_start = 1'b1;
               wb_pop    = gnt;
               spi_wdata = wbyte_sel;
               state_nx  = WAIT;
            end
         end
         WAIT: begin
            if (spi_rx_valid)  state_nx = (cnt == len_q) ? DONE : ISSUE;
            else if (timeout)  state_nx = DONE;
         end
         DONE: begin
            done     = gnt;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt     <= 2'b00;
         len_q   <= '0;
         cnt     <= '0;
         last    <= 1'b1;
         wdata_q <= 8'h00;
         rb_vld  <= 2'b00;
         rb_data <= 8'h00;
      end else begin
         rb_vld <= 2'b00;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt   <= pick ? 2'b10 : 2'b01;
                  len_q <= pick ? len1 : len0;
                  cnt   <= '0;
               end
            end
            ISSUE: begin
               if (spi_rdy) wdata_q <= wbyte_sel;
            end
            WAIT: begin
               if (spi_rx_valid) begin
                  rb_data <= spi_rdata;
                  rb_vld  <= gnt;
                  if (cnt != len_q) cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               last <= gnt[1];
               gnt  <= 2'b00;
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_BURST_TIMEOUT_EN
   localparam int WD_W = $clog2(TO_CYC + 1);

   logic [WD_W-1:0] wd;
   logic            to_q;

   // wd holds the number of cycles elapsed since the last spi_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd   <= '0;
         to_q <= 1'b0;
      end else begin
         if (spi_start)          wd <= WD_W'(1);
         else if (state == WAIT) wd <= wd + WD_W'(1);
         if (timeout)            to_q <= 1'b1;
         else if (state == DONE) to_q <= 1'b0;
      end
   end

   assign timeout = (state == WAIT) && !spi_rx_valid && (wd >= WD_W'(TO_CYC - 1));
   assign err     = (state == DONE) && to_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule
